// File: rtl/nand_page_reader.sv
// NAND page reader: issues a read command plus a 3-cycle address to the source
// flash, waits for ready, then strobes out one page byte by byte onto a
// valid/ready stream. Every flash strobe comes straight from a flop.
module nand_page_reader #(
   parameter int PAGE_BYTES = 512,
   parameter int RB_GUARD   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [8:0] page_addr,
   output logic       busy,
   output logic       page_done,
   output logic [7:0] f_io_out,
   output logic       f_io_oe,
   input  logic [7:0] f_io_in,
   output logic       f_cle,
   output logic       f_ale,
   output logic       f_wen,
   output logic       f_ren,
   input  logic       f_rb,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready
);

   localparam int CW = $clog2(PAGE_BYTES);
   localparam int GW = (RB_GUARD < 1) ? 1 : $clog2(RB_GUARD + 1);

   typedef enum logic [3:0] {
      IDLE, CMD_L, CMD_H, ADDR0_L, ADDR0_H, ADDR1_L, ADDR1_H,
      ADDR2_L, ADDR2_H, WAIT_RB, READ_L, READ_H, DRAIN, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [8:0]    addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] guard_q, guard_d;
   logic          rb_q, rb_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [7:0]    io_out_q, io_out_d;
   logic          io_oe_q, io_oe_d;
   logic          cle_q, cle_d;
   logic          ale_q, ale_d;
   logic          wen_q, wen_d;
   logic          ren_q, ren_d;
   logic          m_valid_q, m_valid_d;
   logic [7:0]    m_data_q, m_data_d;
   logic          handshake_s;

   assign busy      = busy_q;
   assign page_done = done_q;
   assign f_io_out  = io_out_q;
   assign f_io_oe   = io_oe_q;
   assign f_cle     = cle_q;
   assign f_ale     = ale_q;
   assign f_wen     = wen_q;
   assign f_ren     = ren_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;

   // Sequencing: next state, address latch, byte counter, tWB guard and output slot.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      guard_d     = guard_q;
      rb_d        = f_rb;
      handshake_s = m_valid_q & m_ready;
      m_data_d    = m_data_q;
      if (handshake_s) begin
         m_valid_d = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = page_addr;
               state_d = CMD_L;
            end else begin
               state_d = IDLE;
            end
         end
         CMD_L:   state_d = CMD_H;
         CMD_H:   state_d = ADDR0_L;
         ADDR0_L: state_d = ADDR0_H;
         ADDR0_H: state_d = ADDR1_L;
         ADDR1_L: state_d = ADDR1_H;
         ADDR1_H: state_d = ADDR2_L;
         ADDR2_L: state_d = ADDR2_H;
         ADDR2_H: begin
            guard_d = '0;
            state_d = WAIT_RB;
         end
         WAIT_RB: begin
            // The flash may not have pulled R/B low yet right after the
            // last address cycle, so the first few samples are not trusted.
            if (guard_q < GW'(RB_GUARD)) begin
               guard_d = guard_q + GW'(1);
            end else if (rb_q) begin
               state_d = READ_L;
            end else begin
               state_d = WAIT_RB;
            end
         end
         READ_L: begin
            m_data_d  = f_io_in;
            m_valid_d = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CW'(PAGE_BYTES - 1)) begin
               state_d = DRAIN;
            end else begin
               state_d = READ_H;
            end
         end
         READ_H: begin
            // Only strobe the next byte when the stream slot frees this cycle.
            if (!m_valid_q || handshake_s) begin
               state_d = READ_L;
            end else begin
               state_d = READ_H;
            end
         end
         DRAIN: begin
            if (handshake_s) begin
               state_d = DONE;
            end else begin
               state_d = DRAIN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Pad and status outputs decoded from the upcoming state so the flops hold them during it.
   always_comb begin
      busy_d   = (state_d != IDLE);
      done_d   = (state_d == DONE);
      io_out_d = 8'h00;
      io_oe_d  = 1'b0;
      cle_d    = 1'b0;
      ale_d    = 1'b0;
      wen_d    = 1'b1;
      ren_d    = 1'b1;
      case (state_d)
         CMD_L, CMD_H: begin
            io_oe_d = 1'b1;
            cle_d   = 1'b1;
            wen_d   = (state_d != CMD_L);
         end
         ADDR0_L, ADDR0_H: begin
            io_oe_d = 1'b1;
            ale_d   = 1'b1;
            wen_d   = (state_d != ADDR0_L);
         end
         ADDR1_L, ADDR1_H: begin
            io_oe_d  = 1'b1;
            ale_d    = 1'b1;
            io_out_d = addr_d[7:0];
            wen_d    = (state_d != ADDR1_L);
         end
         ADDR2_L, ADDR2_H: begin
            io_oe_d  = 1'b1;
            ale_d    = 1'b1;
            io_out_d = {7'b0000000, addr_d[8]};
            wen_d    = (state_d != ADDR2_L);
         end
         READ_L:  ren_d = 1'b0;
         default: ren_d = 1'b1;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= 9'd0;
         cnt_q     <= '0;
         guard_q   <= '0;
         rb_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         io_out_q  <= 8'h00;
         io_oe_q   <= 1'b0;
         cle_q     <= 1'b0;
         ale_q     <= 1'b0;
         wen_q     <= 1'b1;
         ren_q     <= 1'b1;
         m_valid_q <= 1'b0;
         m_data_q  <= 8'h00;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         cnt_q     <= cnt_d;
         guard_q   <= guard_d;
         rb_q      <= rb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         io_out_q  <= io_out_d;
         io_oe_q   <= io_oe_d;
         cle_q     <= cle_d;
         ale_q     <= ale_d;
         wen_q     <= wen_d;
         ren_q     <= ren_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
      end
   end

endmodule

// File: tb/tb_nand_page_reader.sv
// Bench for nand_page_reader: behavioural flash model, scoreboard of expected
// pad bytes and stream bytes, one task per scenario.
module tb_nand_page_reader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [8:0] page_addr = 9'd0;
   logic       busy, page_done;
   logic [7:0] f_io_out;
   logic       f_io_oe;
   logic [7:0] f_io_in;
   logic       f_cle, f_ale, f_wen, f_ren;
   logic       f_rb = 1'b1;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready = 1'b1;

   int errors = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic [8:0] pad_q[$];
   int         hs_cnt = 0;
   int         done_cnt = 0;

   // flash model state
   int         rb_d = 0, rb_l = 0;
   int         rb_hi = 0, rb_lo = 0;
   bit         rb_active = 0, rb_done = 1;
   int         nadr = 0, idx = 0;
   logic [7:0] a1 = 8'h00;
   logic [8:0] fpage = 9'd0;
   logic       wen_prev = 1'b1, ren_prev = 1'b1;
   logic       pv_valid = 1'b0, pv_ready = 1'b0, pv_rst = 1'b1, pv_done = 1'b0;
   logic [7:0] pv_data = 8'h00;

   always #5 clk = ~clk;

   nand_page_reader dut (
      .clk(clk), .rst(rst), .start(start), .page_addr(page_addr),
      .busy(busy), .page_done(page_done),
      .f_io_out(f_io_out), .f_io_oe(f_io_oe), .f_io_in(f_io_in),
      .f_cle(f_cle), .f_ale(f_ale), .f_wen(f_wen), .f_ren(f_ren), .f_rb(f_rb),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
   );

   function automatic logic [7:0] fdata(input logic [8:0] p, input int i);
      logic [15:0] t;
      t = 16'(i) * 16'd37 + 16'(p) * 16'd11 + 16'(i >> 8) * 16'd101;
      return t[7:0];
   endfunction

   assign f_io_in = (f_ren === 1'b0) ? fdata(fpage, idx) : 8'h00;

   // Flash model and stream monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [8:0] e9;
      logic [7:0] e8;
      // ready/busy sequencing after the last address byte
      if (rb_active) begin
         if (rb_hi > 0) rb_hi--;
         else if (rb_lo > 0) begin f_rb = 1'b0; rb_lo--; end
         else begin f_rb = 1'b1; rb_active = 0; rb_done = 1; end
      end
      // bus write latch on f_wen rising
      if (wen_prev === 1'b0 && f_wen === 1'b1) begin
         checks++;
         if (pad_q.size() == 0) begin
            errors++;
            $display("FAIL pad_unexpected got cle=%0b byte=%02h required none", f_cle, f_io_out);
         end else begin
            e9 = pad_q.pop_front();
            if ({f_cle, f_io_out} !== e9 || f_io_oe !== 1'b1 || f_cle === f_ale) begin
               errors++;
               $display("FAIL pad_byte got cle=%0b ale=%0b oe=%0b byte=%02h required cle=%0b byte=%02h",
                        f_cle, f_ale, f_io_oe, f_io_out, e9[8], e9[7:0]);
            end
         end
         if (f_cle === 1'b1) begin
            nadr = 0; idx = 0;
         end else if (f_ale === 1'b1) begin
            if (nadr == 1) a1 = f_io_out;
            if (nadr == 2) begin
               fpage = {f_io_out[0], a1};
               rb_hi = rb_d; rb_lo = rb_l; rb_active = 1; rb_done = 0; f_rb = 1'b1;
            end
            nadr++;
         end
      end
      if (ren_prev === 1'b1 && f_ren === 1'b0 && !rb_done) begin
         errors++;
         $display("FAIL ren_before_ready got f_ren=0 required 1 while flash busy");
      end
      if (ren_prev === 1'b0 && f_ren === 1'b1) idx++;
      if (f_io_oe === 1'b1 && f_ren === 1'b0) begin
         errors++;
         $display("FAIL oe_with_ren got oe=1 ren=0 required exclusive");
      end
      if (f_ren === 1'b0 && m_valid === 1'b1) begin
         errors++;
         $display("FAIL ren_slot_full got f_ren=0 m_valid=1 required ren high");
      end
      // stream handshake scoreboard
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
         checks++;
         hs_cnt++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_extra got %02h required no byte", m_data);
         end else begin
            e8 = exp_q.pop_front();
            if (m_data !== e8) begin
               errors++;
               $display("FAIL stream_byte got %02h required %02h at hs %0d", m_data, e8, hs_cnt);
            end
         end
      end
      if (!pv_rst && rst !== 1'b1 && pv_valid === 1'b1 && pv_ready !== 1'b1 &&
          (m_valid !== 1'b1 || m_data !== pv_data)) begin
         errors++;
         $display("FAIL stream_hold got v=%0b d=%02h required v=1 d=%02h", m_valid, m_data, pv_data);
      end
      if (page_done === 1'b1) begin
         done_cnt++;
         if (pv_done === 1'b1) begin
            errors++;
            $display("FAIL done_width got 2 cycles required 1");
         end
      end
      wen_prev = f_wen; ren_prev = f_ren;
      pv_valid = m_valid; pv_ready = m_ready; pv_data = m_data; pv_rst = rst; pv_done = page_done;
   end

   task automatic check_reset_outputs(input string nm);
      logic [17:0] got;
      got = {busy, page_done, f_io_out, f_io_oe, f_cle, f_ale, f_wen, f_ren, m_valid};
      checks++;
      if (got !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00} >> 2 ||
          m_data !== 8'h00) begin
         errors++;
         $display("FAIL %s got busy/done/io/oe/cle/ale/wen/ren/valid=%b data=%02h required 0/0/00/0/0/0/1/1/0 data=00",
                  nm, got, m_data);
      end
   endtask

   // Run one page; mode 0 = m_ready high, mode 1 = random with one 50-cycle stall.
   task automatic run_page(input logic [8:0] pg, input int d, input int l, input int mode,
                           input bit spam, input int abort_at);
      int cyc, hold, done0;
      bit held, aborted;
      pad_q.push_back({1'b1, 8'h00});
      pad_q.push_back({1'b0, 8'h00});
      pad_q.push_back({1'b0, pg[7:0]});
      pad_q.push_back({1'b0, 7'b0000000, pg[8]});
      for (int i = 0; i < 512; i++) exp_q.push_back(fdata(pg, i));
      rb_d = d; rb_l = l; hs_cnt = 0; done0 = done_cnt;
      hold = 0; held = 0; aborted = 0; cyc = 0;
      m_ready = 1'b1;
      page_addr = pg; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_on_start got %0b required 1", busy);
      end
      while (page_done !== 1'b1 && cyc < 20000) begin
         if (mode == 1) begin
            if (hold > 0) begin m_ready = 1'b0; hold--; end
            else if (!held && hs_cnt >= 100) begin held = 1; hold = 49; m_ready = 1'b0; end
            else m_ready = 1'($urandom_range(0, 1));
         end
         if (spam) begin start = 1'b1; page_addr = 9'($urandom); end
         if (abort_at > 0 && hs_cnt >= abort_at) begin aborted = 1; break; end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (aborted) begin
         rst = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
         check_reset_outputs("reset_mid_page");
         exp_q.delete(); pad_q.delete();
         repeat (6) @(posedge clk);
         #1;
         checks++;
         if (done_cnt != done0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got done=%0d busy=%0b required done=%0d busy=0",
                     done_cnt, busy, done0);
         end
         return;
      end
      checks++;
      if (cyc >= 20000) begin
         errors++;
         $display("FAIL page_timeout got no page_done required pulse within 20000 cycles");
         return;
      end
      checks++;
      if (hs_cnt != 512 || exp_q.size() != 0 || pad_q.size() != 0) begin
         errors++;
         $display("FAIL page_count got hs=%0d left=%0d pad_left=%0d required 512/0/0",
                  hs_cnt, exp_q.size(), pad_q.size());
      end
      m_ready = 1'b1;
      if (spam) begin start = 1'b1; page_addr = 9'h0F0; end
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || page_done !== 1'b0 || done_cnt != done0 + 1) begin
         errors++;
         $display("FAIL page_end got busy=%0b done=%0b pulses=%0d required 0/0/%0d",
                  busy, page_done, done_cnt - done0, 1);
      end
      if (spam) begin
         repeat (4) @(posedge clk);
         #1;
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done got busy=%0b required 0", busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_basic();
      run_page(9'h1A5, 0, 20, 0, 1'b0, 0);
   endtask

   task automatic test_backpressure();
      run_page(9'h0C3, 0, 5, 1, 1'b0, 0);
   endtask

   task automatic test_rb_guard();
      run_page(9'h02E, 1, 10, 0, 1'b0, 0);
   endtask

   task automatic test_start_spam();
      run_page(9'h111, 0, 8, 0, 1'b1, 0);
   endtask

   task automatic test_reset_mid();
      run_page(9'h055, 0, 6, 0, 1'b0, 200);
      run_page(9'h003, 0, 6, 0, 1'b0, 0);
   endtask

   task automatic test_back_to_back();
      int d0;
      d0 = done_cnt;
      run_page(9'h000, 0, 4, 0, 1'b0, 0);
      run_page(9'h1FF, 0, 4, 0, 1'b0, 0);
      checks++;
      if (done_cnt != d0 + 2) begin
         errors++;
         $display("FAIL back_to_back_done got %0d required %0d", done_cnt - d0, 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_rb_guard();
      test_start_spam();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog got no finish required finish before limit");
      $fatal(1, "watchdog");
   end

endmodule
